// File: rtl/tick_period_meter.sv
// tick_period_meter
// Measures the number of iClk cycles between consecutive one-cycle strobes.
// Each completed interval is reported on oPeriod with a one-cycle oValid
// pulse. oLocked rises after LOCK_MATCHES consecutive repeats of the same
// period. oTimeout is a level that rises when strobes stop arriving.

module tick_period_meter #(
    parameter int                  CNT_BITS       = 8,
    parameter logic [CNT_BITS-1:0] TIMEOUT_COUNTS = 8'd200,
    parameter int                  LOCK_MATCHES   = 3,
    parameter int                  LOCK_BITS      = 2
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iEnable,
    input  logic                iTick,
    output logic [CNT_BITS-1:0] oPeriod,
    output logic                oValid,
    output logic                oLocked,
    output logic                oTimeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

    // Last counter value that can still be followed by a strobe without timing out.
    localparam logic [CNT_BITS-1:0]  TimeoutLast = TIMEOUT_COUNTS - {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [LOCK_BITS-1:0] LockMax     = LOCK_BITS'(LOCK_MATCHES);

    state_t               state;
    logic [CNT_BITS-1:0]  cnt;
    logic [LOCK_BITS-1:0] matchCnt;
    // Set once a measurement exists that the next period may be compared against.
    logic                 havePrev;

    logic [CNT_BITS-1:0]  period;
    logic                 isMatch;
    logic [LOCK_BITS-1:0] nextMatch;

    // Period candidate and the match count it would produce if a strobe arrives now.
    always_comb begin
        period    = cnt + {{(CNT_BITS-1){1'b0}}, 1'b1};
        isMatch   = havePrev && (period == oPeriod);
        nextMatch = {LOCK_BITS{1'b0}};
        if (isMatch) begin
            if (matchCnt == LockMax) begin
                nextMatch = LockMax;
            end else begin
                nextMatch = matchCnt + {{(LOCK_BITS-1){1'b0}}, 1'b1};
            end
        end else begin
            nextMatch = {LOCK_BITS{1'b0}};
        end
    end

    // Measurement state machine with all outputs registered.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state    <= IDLE;
            cnt      <= {CNT_BITS{1'b0}};
            matchCnt <= {LOCK_BITS{1'b0}};
            havePrev <= 1'b0;
            oPeriod  <= {CNT_BITS{1'b0}};
            oValid   <= 1'b0;
            oLocked  <= 1'b0;
            oTimeout <= 1'b0;
        end else begin
            oValid <= 1'b0;
            if (!iEnable) begin
                // Disable wins over everything; oPeriod keeps the last result.
                state    <= IDLE;
                cnt      <= {CNT_BITS{1'b0}};
                matchCnt <= {LOCK_BITS{1'b0}};
                havePrev <= 1'b0;
                oLocked  <= 1'b0;
                oTimeout <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt      <= {CNT_BITS{1'b0}};
                        matchCnt <= {LOCK_BITS{1'b0}};
                        havePrev <= 1'b0;
                        if (iTick) begin
                            state <= MEASURE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    MEASURE: begin
                        if (iTick) begin
                            // A strobe on the last allowed cycle is still a measurement.
                            oPeriod  <= period;
                            oValid   <= 1'b1;
                            oLocked  <= (nextMatch == LockMax);
                            matchCnt <= nextMatch;
                            havePrev <= 1'b1;
                            cnt      <= {CNT_BITS{1'b0}};
                        end else if (cnt == TimeoutLast) begin
                            state    <= TIMEOUT;
                            oTimeout <= 1'b1;
                            oLocked  <= 1'b0;
                            matchCnt <= {LOCK_BITS{1'b0}};
                            havePrev <= 1'b0;
                            cnt      <= {CNT_BITS{1'b0}};
                        end else begin
                            cnt <= cnt + {{(CNT_BITS-1){1'b0}}, 1'b1};
                        end
                    end
                    TIMEOUT: begin
                        cnt <= {CNT_BITS{1'b0}};
                        if (iTick) begin
                            // New reference edge only: no period is reported.
                            oTimeout <= 1'b0;
                            state    <= MEASURE;
                        end else begin
                            oTimeout <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        cnt      <= {CNT_BITS{1'b0}};
                        matchCnt <= {LOCK_BITS{1'b0}};
                        havePrev <= 1'b0;
                        oLocked  <= 1'b0;
                        oTimeout <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed self-checking bench for tick_period_meter.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_tick_period_meter;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       iEnable;
    logic       iTick;
    logic [7:0] oPeriod;
    logic       oValid;
    logic       oLocked;
    logic       oTimeout;

    int checkCnt = 0;
    int failCnt  = 0;

    int jitPer[7]  = '{14, 14, 15, 14, 14, 14, 14};
    bit jitLock[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    always #5 iClk = ~iClk;

    tick_period_meter #(
        .CNT_BITS      (8),
        .TIMEOUT_COUNTS(8'd200),
        .LOCK_MATCHES  (3),
        .LOCK_BITS     (2)
    ) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iEnable (iEnable),
        .iTick   (iTick),
        .oPeriod (oPeriod),
        .oValid  (oValid),
        .oLocked (oLocked),
        .oTimeout(oTimeout)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        if (obs !== exp) begin
            failCnt++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic gap(input int n);
        iTick = 1'b0;
        repeat (n) @(negedge iClk);
    endtask

    // One-cycle strobe; returns on the falling edge after it was sampled.
    task automatic strobe();
        iTick = 1'b1;
        @(negedge iClk);
        iTick = 1'b0;
    endtask

    task automatic checkMeas(input string tag, input logic v, input int p, input logic l);
        checkVal({tag, "_valid"},  {31'd0, oValid},  {31'd0, v});
        checkVal({tag, "_period"}, {24'd0, oPeriod}, p);
        checkVal({tag, "_locked"}, {31'd0, oLocked}, {31'd0, l});
    endtask

    initial begin
        iRst    = 1'b1;
        iEnable = 1'b0;
        iTick   = 1'b0;
        repeat (2) @(negedge iClk);
        checkVal("rst_period",  {24'd0, oPeriod},  32'd0);
        checkVal("rst_valid",   {31'd0, oValid},   32'd0);
        checkVal("rst_locked",  {31'd0, oLocked},  32'd0);
        checkVal("rst_timeout", {31'd0, oTimeout}, 32'd0);
        iRst    = 1'b0;
        iEnable = 1'b1;
        @(negedge iClk);

        // Periodic 14: reference strobe, then four measurements; lock on the 4th.
        strobe();
        checkVal("first_no_valid", {31'd0, oValid}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            gap(13);
            strobe();
            checkMeas("p14", 1'b1, 14, (i == 4));
        end
        gap(1);
        checkVal("p14_valid_drop", {31'd0, oValid},  32'd0);
        checkVal("p14_lock_hold",  {31'd0, oLocked}, 32'd1);

        // Disable while locked: lock clears, period is held.
        iEnable = 1'b0;
        @(negedge iClk);
        checkMeas("dis", 1'b0, 14, 1'b0);
        iEnable = 1'b1;
        gap(3);
        strobe();
        checkVal("reen_no_valid", {31'd0, oValid}, 32'd0);

        // Jitter: the 15 resets the match count, lock needs three fresh repeats.
        for (int i = 0; i < 7; i++) begin
            gap(jitPer[i] - 1);
            strobe();
            checkMeas("jit", 1'b1, jitPer[i], jitLock[i]);
        end

        // Timeout exactly 200 cycles after the last strobe.
        gap(199);
        checkVal("to_not_yet", {31'd0, oTimeout}, 32'd0);
        gap(1);
        checkVal("to_set",     {31'd0, oTimeout}, 32'd1);
        checkVal("to_unlock",  {31'd0, oLocked},  32'd0);
        gap(10);
        strobe();
        checkVal("to_clear", {31'd0, oTimeout}, 32'd0);
        checkMeas("to_ref", 1'b0, 14, 1'b0);

        // Strobe on the timeout cycle is a measurement of 200.
        gap(199);
        strobe();
        checkMeas("p200", 1'b1, 200, 1'b0);
        checkVal("p200_no_to", {31'd0, oTimeout}, 32'd0);

        // Back-to-back strobes: period 1; locks on the 4th equal period.
        for (int i = 0; i < 4; i++) begin
            strobe();
            checkMeas("p1", 1'b1, 1, (i == 3));
        end

        // Asynchronous reset mid-count.
        gap(5);
        #2;
        iRst = 1'b1;
        #1;
        checkVal("arst_period",  {24'd0, oPeriod},  32'd0);
        checkVal("arst_valid",   {31'd0, oValid},   32'd0);
        checkVal("arst_locked",  {31'd0, oLocked},  32'd0);
        checkVal("arst_timeout", {31'd0, oTimeout}, 32'd0);
        @(negedge iClk);
        iRst = 1'b0;
        strobe();
        checkVal("arst_first_no_valid", {31'd0, oValid}, 32'd0);
        gap(4);
        strobe();
        checkMeas("arst_p5", 1'b1, 5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
        $finish;
    end

endmodule
